// File: rtl/rf_recovery_if.sv
// Bus bundle for rf_recovery: agreed-write capture, error flag and replay stream.
// master: comparator/core side; slave: rf_recovery. rec_count exists only with RF_RECOVERY_CNT_EN.
interface rf_recovery_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  cmp_w_en;
    logic [ADDR_WIDTH-1:0] cmp_w_addr;
    logic [DATA_WIDTH-1:0] cmp_w_data;
    logic                  error_i;
    logic                  halt_o;
    logic                  rec_w_en;
    logic [ADDR_WIDTH-1:0] rec_w_addr;
    logic [DATA_WIDTH-1:0] rec_w_data;
    logic                  done_o;
`ifdef RF_RECOVERY_CNT_EN
    logic [7:0]            rec_count;
`endif

    modport master (
        output cmp_w_en, cmp_w_addr, cmp_w_data, error_i,
        input  halt_o, rec_w_en, rec_w_addr, rec_w_data, done_o
`ifdef RF_RECOVERY_CNT_EN
        , input rec_count
`endif
    );

    modport slave (
        input  cmp_w_en, cmp_w_addr, cmp_w_data, error_i,
        output halt_o, rec_w_en, rec_w_addr, rec_w_data, done_o
`ifdef RF_RECOVERY_CNT_EN
        , output rec_count
`endif
    );
endinterface

// File: rtl/rf_recovery.sv
// Shadow register file plus replay FSM restoring both cores after a mismatch.
// Ports: clk, rst_n (async active-low), bus (rf_recovery_if.slave).
// Optional macro RF_RECOVERY_CNT_EN adds the saturating 8-bit bus.rec_count.
module rf_recovery #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_recovery_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HALT, REPLAY, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH:0]   NREGS = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
    logic                  capture;
    logic                  replay;

    // Entry 0 is never written, so it stays at its reset value of zero.
    assign capture = (state == IDLE) && bus.cmp_w_en && !bus.error_i &&
                     (bus.cmp_w_addr != '0) &&
                     ({1'b0, bus.cmp_w_addr} < NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= ONE;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (capture) begin
                shadow[bus.cmp_w_addr] <= bus.cmp_w_data;
            end
            unique case (state)
                IDLE: begin
                    if (bus.error_i) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    state <= REPLAY;
                    ptr   <= ONE;
                end
                REPLAY: begin
                    // ptr holds at the last register instead of wrapping.
                    if (ptr == LAST) begin
                        state <= DONE;
                    end else begin
                        ptr <= ptr + ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign replay         = (state == REPLAY);
    assign bus.halt_o     = (state != IDLE);
    assign bus.rec_w_en   = replay;
    assign bus.rec_w_addr = replay ? ptr : '0;
    assign bus.rec_w_data = replay ? shadow[ptr] : '0;
    assign bus.done_o     = (state == DONE);

`ifdef RF_RECOVERY_CNT_EN
    logic [7:0] rec_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_count <= '0;
        end else if ((state == IDLE) && bus.error_i &&
                     (rec_count != 8'hFF)) begin
            rec_count <= rec_count + 8'd1;
        end
    end

    assign bus.rec_count = rec_count;
`endif
endmodule

// File: tb/tb_rf_recovery.sv
// Scoreboard bench for rf_recovery: random and directed writes/errors
// against an abstract shadow model with a queue of expected replay writes.
module tb_rf_recovery;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int HL = NR + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rf_recovery_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rf_recovery #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_REGS(NR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [DW-1:0] mshadow [NR];
    wr_t           expq [$];
    int            busy;
    int            mcount;
    bit            exp_halt;
    bit            exp_done;
    bit            exp_rec;
    int            checks;
    int            errors;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Abstract model: an error seen while not busy snapshots the agreed
    // register file as NR-1 replay writes and makes the block busy for HL edges.
    task automatic model_edge(input logic en, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic err);
        if (busy > 0) begin
            busy--;
        end else if (err) begin
            for (int i = 1; i < NR; i++) begin
                expq.push_back('{AW'(i), mshadow[i]});
            end
            busy = HL;
            if (mcount < 255) mcount++;
        end else if (en && a != 0 && int'(a) < NR) begin
            mshadow[a] = d;
        end
        exp_halt = (busy > 0);
        exp_done = (busy == 1);
        exp_rec  = (busy >= 2) && (busy <= HL - 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mshadow[i] = '0;
        expq.delete();
        busy     = 0;
        mcount   = 0;
        exp_halt = 1'b0;
        exp_done = 1'b0;
        exp_rec  = 1'b0;
    endtask

    task automatic cycle(input logic en, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic err);
        bus.cmp_w_en   = en;
        bus.cmp_w_addr = a;
        bus.cmp_w_data = d;
        bus.error_i    = err;
        @(posedge clk);
        model_edge(en, a, d, err);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_halt", bus.halt_o, 1'b0);
        chk("rst_rec_en", bus.rec_w_en, 1'b0);
        chk("rst_done", bus.done_o, 1'b0);
        chk("rst_addr", bus.rec_w_addr, '0);
        chk("rst_data", bus.rec_w_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("halt", bus.halt_o, exp_halt);
            chk("done", bus.done_o, exp_done);
            chk("rec_en", bus.rec_w_en, exp_rec);
            if (bus.rec_w_en) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL replay_extra: addr %0d with empty queue",
                             bus.rec_w_addr);
                end else begin
                    wr_t w;
                    w = expq.pop_front();
                    chk("rec_addr", bus.rec_w_addr, w.a);
                    chk("rec_data", bus.rec_w_data, w.d);
                end
            end else begin
                chk("idle_addr", bus.rec_w_addr, '0);
                chk("idle_data", bus.rec_w_data, '0);
            end
`ifdef RF_RECOVERY_CNT_EN
            chk("rec_count", bus.rec_count, mcount[7:0]);
`endif
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst_n          = 1'b0;
        bus.cmp_w_en   = 1'b0;
        bus.cmp_w_addr = '0;
        bus.cmp_w_data = '0;
        bus.error_i    = 1'b0;
        #2;
        chk("init_halt", bus.halt_o, 1'b0);
        chk("init_rec_en", bus.rec_w_en, 1'b0);
        chk("init_done", bus.done_o, 1'b0);
        chk("init_addr", bus.rec_w_addr, '0);
        chk("init_data", bus.rec_w_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // capture and replay
        cycle(1'b1, 5'd10, 32'd100, 1'b0);
        cycle(1'b1, 5'd11, 32'd101, 1'b0);
        cycle(1'b1, 5'd31, 32'hDEADBEEF, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        idle(HL + 2);

        // write in the same cycle as the error is dropped
        cycle(1'b1, 5'd5, 32'd7, 1'b0);
        idle(2);
        cycle(1'b1, 5'd5, 32'd9, 1'b1);
        idle(HL + 2);

        // writes during halt and to r0 are ignored
        cycle(1'b1, 5'd12, 32'd44, 1'b0);
        cycle(1'b1, 5'd0, 32'd55, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b1, 5'd0, 32'd55, 1'b0);
        cycle(1'b1, 5'd12, 32'd3, 1'b0);
        idle(HL);
        cycle(1'b0, '0, '0, 1'b1);
        idle(HL + 2);

        // error during replay neither restarts nor extends
        cycle(1'b0, '0, '0, 1'b1);
        idle(15);
        cycle(1'b0, '0, '0, 1'b1);
        idle(HL + 4);

        // error held high across DONE restarts on the first IDLE edge
        cycle(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < HL + 3; i++) cycle(1'b0, '0, '0, 1'b1);
        idle(HL + 2);

        // reset mid-replay, then replay must be all zeros
        cycle(1'b0, '0, '0, 1'b1);
        idle(8);
        #2;
        pulse_reset();
        idle(2);
        cycle(1'b0, '0, '0, 1'b1);
        idle(HL + 2);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, NR - 1)),
                  DW'($urandom),
                  1'($urandom_range(0, 40) == 0));
        end
        idle(HL + 2);

`ifdef RF_RECOVERY_CNT_EN
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b1);
            idle(HL + 1);
        end
        chk("count3", bus.rec_count, 8'd3);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, '0, '0, 1'b1);
            idle(HL);
        end
        idle(2);
        chk("count_sat", bus.rec_count, 8'd255);
`endif

        idle(2);
        chk("queue_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
